// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with a valid/ready handshake, a synchronous flush and an
// optional second (skid) entry that lets in_ready come straight from a flop.
module pipe_stage_buf #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Handshake: a beat moves on a side exactly in a cycle where valid && ready is
  // high at the rising edge; a producer holds valid and data until that happens.

  // The state encoding equals the occupancy, so count doubles as the FSM debug view.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             consume;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

  // With a skid entry, in_ready is a flop; without it, it looks through to out_ready.
  assign in_ready  = SKID ? ready_q : (out_ready | ~out_valid);

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Squash without touching the data registers; a same-cycle beat is dropped.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept && SKID) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  // A stalled head beat must stay put until downstream takes it.
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> $stable(out_data));

endmodule
